// File: rtl/spi_pkg.sv
// Shared types for the SPI frame controller: FSM states, captured frame config
// and the SCLK edge-count helper.
package spi_pkg;

  localparam int SPI_DIV_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_DONE
  } spi_xfer_state_e;

  // clkdiv is sized by SPI_DIV_W; a DIV_W override on the controller must track it.
  typedef struct packed {
    logic [SPI_DIV_W-1:0] clkdiv;
    logic                 cpol;
    logic                 cpha;
    logic                 lsb_first;
  } spi_cfg_t;

  function automatic int xfer_edges(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: ticks every clkdiv+1 cycles while running and tags
// each tick during XFER as a leading or trailing SCLK edge.
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_xfer,
  input  logic             i_sclk_idle,
  input  logic [DIV_W-1:0] i_clkdiv,
  output logic             o_tick,
  output logic             o_lead,
  output logic             o_trail
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick  = i_run && (r_cnt == '0);
  // SCLK still at its idle level means the coming toggle moves away from idle.
  assign o_lead  = o_tick && i_xfer && i_sclk_idle;
  assign o_trail = o_tick && i_xfer && !i_sclk_idle;

  // Counting down clkdiv..0 yields clkdiv+1 cycles, so all-ones never overflows.
  // NOTE: non-blocking assignments in clocked blocks so every flop sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || o_tick) begin
      r_cnt <= i_clkdiv;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master frame sequencer: loads the TX shifter, generates SCLK/CS_N,
// issues shift enables and assembles MISO into an RX word.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = SPI_DIV_W
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [DIV_W-1:0]  clkdiv_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic              abort_i,
  output logic [DATA_W-1:0] sh_data_o,
  output logic              sh_valid_o,
  input  logic              sh_ready_i,
  output logic              sh_en_o,
  output logic              sh_rl_o,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              cs_n_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o
);

  localparam int                EDGES     = xfer_edges(DATA_W);
  localparam int                EDGE_W    = $clog2(EDGES);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES - 1);

  spi_xfer_state_e   r_state;
  spi_xfer_state_e   w_next;
  spi_cfg_t          r_cfg;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx_sr;
  logic [DATA_W-1:0] r_rx_data;
  logic [EDGE_W-1:0] r_edge;
  logic              r_sclk;
  logic              r_cs_n;

  logic w_accept;
  logic w_abort;
  logic w_run;
  logic w_xfer;
  logic w_tick;
  logic w_lead;
  logic w_trail;
  logic w_last_edge;
  logic w_shift;
  logic w_sample;

  assign w_accept    = start_valid_i && (r_state == ST_IDLE);
  assign w_abort     = abort_i && (r_state != ST_IDLE);
  assign w_run       = (r_state == ST_SETUP) || (r_state == ST_XFER) || (r_state == ST_HOLD);
  assign w_xfer      = (r_state == ST_XFER);
  assign w_last_edge = (r_edge == LAST_EDGE);

  spi_clk_div #(
    .DIV_W(DIV_W)
  ) u_clk_div (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .i_run      (w_run),
    .i_xfer     (w_xfer),
    .i_sclk_idle(r_sclk == r_cfg.cpol),
    .i_clkdiv   (r_cfg.clkdiv),
    .o_tick     (w_tick),
    .o_lead     (w_lead),
    .o_trail    (w_trail)
  );

  // Edge number is r_edge+1; the first (CPHA=1) or last (CPHA=0) shift edge is skipped.
  assign w_shift  = r_cfg.cpha ? (w_lead && (r_edge != '0)) : (w_trail && !w_last_edge);
  assign w_sample = r_cfg.cpha ? w_trail : w_lead;

  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_LOAD;
      ST_LOAD:  if (sh_ready_i) w_next = ST_SETUP;
      ST_SETUP: if (w_tick) w_next = ST_XFER;
      ST_XFER:  if (w_tick && w_last_edge) w_next = ST_HOLD;
      ST_HOLD:  if (w_tick) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cs_n  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cs_n  <= !((w_next == ST_SETUP) || (w_next == ST_XFER) || (w_next == ST_HOLD));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg <= '0;
      r_tx  <= '0;
    end else if (w_accept) begin
      r_cfg <= '{clkdiv: clkdiv_i, cpol: cpol_i, cpha: cpha_i, lsb_first: lsb_first_i};
      r_tx  <= tx_data_i;
    end
  end

  // SCLK is registered so the pin never carries decode glitches.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk <= 1'b0;
    end else if (w_accept) begin
      r_sclk <= cpol_i;
    end else if (w_abort) begin
      r_sclk <= r_cfg.cpol;
    end else if (w_xfer && w_tick) begin
      r_sclk <= ~r_sclk;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_edge <= '0;
    end else if (!w_xfer) begin
      r_edge <= '0;
    end else if (w_tick) begin
      r_edge <= r_edge + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_sr   <= '0;
      r_rx_data <= '0;
    end else begin
      if (w_sample && !w_abort) begin
        r_rx_sr <= r_cfg.lsb_first ? {miso_i, r_rx_sr[DATA_W-1:1]}
                                   : {r_rx_sr[DATA_W-2:0], miso_i};
      end
      // Publish on the HOLD->DONE transition so data is stable during the rx_valid_o pulse.
      if ((r_state == ST_HOLD) && w_tick && !w_abort) begin
        r_rx_data <= r_rx_sr;
      end
    end
  end

  assign start_ready_o = (r_state == ST_IDLE);
  assign busy_o        = (r_state != ST_IDLE);
  assign sh_valid_o    = (r_state == ST_LOAD);
  assign sh_data_o     = r_tx;
  assign sh_en_o       = w_shift && !w_abort;
  assign sh_rl_o       = r_cfg.lsb_first;
  assign sclk_o        = r_sclk;
  assign cs_n_o        = r_cs_n;
  assign rx_data_o     = r_rx_data;
  assign rx_valid_o    = (r_state == ST_DONE);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Randomized bench for spi_xfer_ctrl: a behavioural TX shifter loops sdo back to
// MISO, and each frame is scored against timing/count rules computed per frame.
module tb_spi_xfer_ctrl;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_valid_i = 1'b0;
  logic              start_ready_o;
  logic [DATA_W-1:0] tx_data_i = '0;
  logic [DIV_W-1:0]  clkdiv_i = '0;
  logic              cpol_i = 1'b0;
  logic              cpha_i = 1'b0;
  logic              lsb_first_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [DATA_W-1:0] sh_data_o;
  logic              sh_valid_o;
  logic              sh_ready_i = 1'b0;
  logic              sh_en_o;
  logic              sh_rl_o;
  logic              miso_i;
  logic              sclk_o;
  logic              cs_n_o;
  logic              busy_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] last_rx_exp = '0;

  always #5 clk_i = ~clk_i;

  spi_xfer_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .start_valid_i(start_valid_i),
    .start_ready_o(start_ready_o),
    .tx_data_i    (tx_data_i),
    .clkdiv_i     (clkdiv_i),
    .cpol_i       (cpol_i),
    .cpha_i       (cpha_i),
    .lsb_first_i  (lsb_first_i),
    .abort_i      (abort_i),
    .sh_data_o    (sh_data_o),
    .sh_valid_o   (sh_valid_o),
    .sh_ready_i   (sh_ready_i),
    .sh_en_o      (sh_en_o),
    .sh_rl_o      (sh_rl_o),
    .miso_i       (miso_i),
    .sclk_o       (sclk_o),
    .cs_n_o       (cs_n_o),
    .busy_o       (busy_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o)
  );

  // Behavioural LR shifter; its serial output is looped back as MISO.
  logic [DATA_W-1:0] r_sh;
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                        r_sh <= '0;
    else if (sh_valid_o && sh_ready_i) r_sh <= sh_data_o;
    else if (sh_en_o)                  r_sh <= sh_rl_o ? (r_sh >> 1) : (r_sh << 1);
  end
  assign miso_i = sh_rl_o ? r_sh[0] : r_sh[DATA_W-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Shift pulses expected on SCLK edges 1..upto: CPHA=0 even edges up to 2N-2, CPHA=1 odd edges 3..2N-1.
  function automatic int exp_shifts(input bit cpha, input int upto);
    int n = 0;
    for (int k = 1; k <= upto; k++) begin
      if (cpha ? ((k % 2 == 1) && (k >= 3) && (k <= 2*DATA_W-1))
               : ((k % 2 == 0) && (k <= 2*DATA_W-2))) n++;
    end
    return n;
  endfunction

  task automatic run_frame(input logic [DATA_W-1:0] tx, input int div, input bit cpol,
                           input bit cpha, input bit lsb, input int stall,
                           input int abort_edge, input bit poke_start);
    int h        = div + 1;
    int load_cyc = stall + 1;
    int busy_exp = load_cyc + h*(2*DATA_W + 2) + 1;
    int c_abort  = (abort_edge > 0) ? load_cyc + h + abort_edge*h : -1;
    int budget   = busy_exp + 20;
    int c = 0, n_busy = 0, n_ready_busy = 0, n_valid = 0, n_valid_cs = 0, n_shift = 0;
    int n_rl_bad = 0, n_cs = 0, n_tog = 0, last_tog = 0, sp_min = 1 << 30, sp_max = 0, n_rxv = 0;
    bit done = 0;
    logic first_sclk = 1'bx;
    logic last_sclk;
    logic [DATA_W-1:0] rx_got = '0;

    @(negedge clk_i);
    tx_data_i = tx; clkdiv_i = DIV_W'(div); cpol_i = cpol; cpha_i = cpha; lsb_first_i = lsb;
    start_valid_i = 1'b1; sh_ready_i = 1'b0; abort_i = 1'b0;
    #1;
    check("start_ready", 32'(start_ready_o), 32'd1);
    last_sclk = sclk_o;
    while (!done && c < budget) begin
      @(negedge clk_i);
      c++;
      if (c == 1) begin
        tx_data_i = DATA_W'($urandom); clkdiv_i = DIV_W'($urandom);
        cpol_i = 1'($urandom); cpha_i = 1'($urandom); lsb_first_i = 1'($urandom);
      end
      start_valid_i = poke_start && (c >= 2) && (c <= busy_exp);
      sh_ready_i    = (c >= load_cyc);
      abort_i       = (c == c_abort);
      #1;
      if (busy_o) n_busy++;
      if (busy_o && start_ready_o) n_ready_busy++;
      if (sh_valid_o) n_valid++;
      if (sh_valid_o && !cs_n_o) n_valid_cs++;
      if (sh_en_o) n_shift++;
      if (busy_o && (sh_rl_o != lsb)) n_rl_bad++;
      if (!cs_n_o) begin
        n_cs++;
        if (n_cs == 1) first_sclk = sclk_o;
        if (sclk_o != last_sclk) begin
          n_tog++;
          if (last_tog > 0) begin
            if (c - last_tog < sp_min) sp_min = c - last_tog;
            if (c - last_tog > sp_max) sp_max = c - last_tog;
          end
          last_tog = c;
        end
      end
      last_sclk = sclk_o;
      if (rx_valid_o) begin
        n_rxv++;
        rx_got = rx_data_o;
      end
      if (!busy_o) done = 1;
    end
    abort_i = 1'b0; start_valid_i = 1'b0; sh_ready_i = 1'b0;

    check("frame_end_seen", 32'(done), 32'd1);
    check("ready_while_busy", n_ready_busy, 0);
    check("load_cycles", n_valid, load_cyc);
    check("cs_low_in_load", n_valid_cs, 0);
    check("sh_rl", n_rl_bad, 0);
    check("end_sclk_idle", 32'(sclk_o), 32'(cpol));
    check("end_cs_n", 32'(cs_n_o), 32'd1);
    if (abort_edge == 0) begin
      check("busy_cycles", n_busy, busy_exp);
      check("cs_low_cycles", n_cs, h*(2*DATA_W + 2));
      check("sclk_lead_level", 32'(first_sclk), 32'(cpol));
      check("sclk_toggles", n_tog, 2*DATA_W);
      check("half_period_min", sp_min, h);
      check("half_period_max", sp_max, h);
      check("sh_en_count", n_shift, DATA_W - 1);
      check("rx_valid_count", n_rxv, 1);
      check("rx_data", 32'(rx_got), 32'(tx));
      check("rx_data_hold", 32'(rx_data_o), 32'(tx));
      last_rx_exp = tx;
    end else begin
      check("abort_exit_cycle", c, c_abort + 1);
      check("abort_toggles", n_tog, abort_edge - 1);
      check("abort_sh_en", n_shift, exp_shifts(cpha, abort_edge - 1));
      check("abort_rx_valid", n_rxv, 0);
      check("abort_rx_hold", 32'(rx_data_o), 32'(last_rx_exp));
    end
  endtask

  task automatic reset_mid_xfer();
    int c = 0;
    @(negedge clk_i);
    tx_data_i = 8'h5A; clkdiv_i = 8'd2; cpol_i = 1'b1; cpha_i = 1'b0; lsb_first_i = 1'b1;
    start_valid_i = 1'b1; sh_ready_i = 1'b1;
    @(negedge clk_i);
    start_valid_i = 1'b0;
    while (cs_n_o && c < 50) begin
      @(negedge clk_i);
      c++;
    end
    repeat (6) @(negedge clk_i);
    check("pre_reset_busy", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_cs_n", 32'(cs_n_o), 32'd1);
    check("rst_sclk", 32'(sclk_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_sh_en", 32'(sh_en_o), 32'd0);
    check("rst_sh_valid", 32'(sh_valid_o), 32'd0);
    check("rst_sh_rl", 32'(sh_rl_o), 32'd0);
    check("rst_rx_data", 32'(rx_data_o), 32'd0);
    check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    sh_ready_i = 1'b0;
    last_rx_exp = '0;
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    check("reset_cs_n", 32'(cs_n_o), 32'd1);
    check("reset_sclk", 32'(sclk_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_sh_valid", 32'(sh_valid_o), 32'd0);
    check("reset_sh_en", 32'(sh_en_o), 32'd0);
    check("reset_sh_rl", 32'(sh_rl_o), 32'd0);
    check("reset_sh_data", 32'(sh_data_o), 32'd0);
    check("reset_rx_data", 32'(rx_data_o), 32'd0);
    check("reset_rx_valid", 32'(rx_valid_o), 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset_ready", 32'(start_ready_o), 32'd1);

    run_frame(8'hA5, 1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_frame(8'h3C, 0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
    run_frame(DATA_W'($urandom), 2, 1'b0, 1'b0, 1'b0, 5, 0, 1'b0);
    run_frame(8'hA5, 1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_frame(DATA_W'($urandom), 1, 1'b0, 1'b1, 1'b0, 0, 5, 1'b0);
    run_frame(DATA_W'($urandom), 255, 1'($urandom), 1'($urandom), 1'($urandom), 1, 0, 1'b1);

    // Abort while idle must not start anything.
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    check("idle_abort_busy", 32'(busy_o), 32'd0);
    check("idle_abort_ready", 32'(start_ready_o), 32'd1);

    for (int i = 0; i < 24; i++) begin
      run_frame(DATA_W'($urandom), int'($urandom_range(0, 5)), 1'($urandom), 1'($urandom),
                1'($urandom), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2*DATA_W)) : 0, 1'b0);
    end

    reset_mid_xfer();
    run_frame(DATA_W'($urandom), 3, 1'b1, 1'b0, 1'b1, 2, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
